// File: rtl/data_mem_responder_if.sv
// Valid/ready request and response channels between the CPU data-memory
// requester (master) and the data-memory responder (slave).
interface data_mem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        req_wen;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_addr, req_wen, req_size, req_unsigned, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_addr, req_wen, req_size, req_unsigned, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/data_mem_responder.sv
// Data-memory responder: little-endian byte RAM accessed at request accept,
// results delayed LATENCY cycles and returned in order through a response FIFO.
module data_mem_responder #(
  parameter int ADDR_WIDTH = 12,
  parameter int LATENCY    = 2,
  parameter int DEPTH      = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  data_mem_responder_if.slave  bus
);
  localparam int IDX_W     = ADDR_WIDTH - 2;
  localparam int MEM_WORDS = 2 ** IDX_W;
  localparam int PW        = 33;
  localparam int PTR_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W     = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_BAD  = 2'b11
  } size_e;

  logic [31:0]      r_mem [MEM_WORDS];
  logic             r_req_ready;
  logic [CNT_W-1:0] r_outstanding;
  logic [CNT_W-1:0] w_out_next;
  logic [PW-1:0]    r_buf [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  size_e            w_size;
  logic             w_accept;
  logic             w_pop;
  logic             w_err;
  logic [IDX_W-1:0] w_idx;
  logic [3:0]       w_be;
  logic [31:0]      w_wlanes;
  logic [31:0]      w_rword;
  logic [31:0]      w_shifted;
  logic [31:0]      w_load;
  logic [PW-1:0]    w_in_pl;
  logic             w_head_vld;
  logic [PW-1:0]    w_head_pl;
  logic [PW-1:0]    w_rsp_pl;

  assign w_size    = size_e'(bus.req_size);
  assign w_accept  = bus.req_valid && r_req_ready;
  assign w_idx     = bus.req_addr[ADDR_WIDTH-1:2];
  assign w_rword   = r_mem[w_idx];
  assign w_shifted = w_rword >> {bus.req_addr[1:0], 3'b000};

  // NOTE: every variable gets a default before the case so no path leaves one unassigned (no latch).
  always_comb begin
    w_err    = (bus.req_addr >> ADDR_WIDTH) != 32'd0;
    w_be     = 4'b0000;
    w_wlanes = bus.req_wdata;
    w_load   = w_shifted;
    case (w_size)
      SZ_BYTE: begin
        w_be     = 4'b0001 << bus.req_addr[1:0];
        w_wlanes = {4{bus.req_wdata[7:0]}};
        w_load   = bus.req_unsigned ? {24'd0, w_shifted[7:0]}
                                    : {{24{w_shifted[7]}}, w_shifted[7:0]};
      end
      SZ_HALF: begin
        w_err    = w_err | bus.req_addr[0];
        w_be     = bus.req_addr[1] ? 4'b1100 : 4'b0011;
        w_wlanes = {2{bus.req_wdata[15:0]}};
        w_load   = bus.req_unsigned ? {16'd0, w_shifted[15:0]}
                                    : {{16{w_shifted[15]}}, w_shifted[15:0]};
      end
      SZ_WORD: begin
        w_err  = w_err | (bus.req_addr[1:0] != 2'b00);
        w_be   = 4'b1111;
        w_load = w_rword;
      end
      default: w_err = 1'b1;
    endcase
    if (w_err || bus.req_wen) w_load = 32'd0;
    w_in_pl = {w_load, w_err};
  end

  // NOTE: the RAM is deliberately left out of reset so stored data survives a reset pulse.
  always_ff @(posedge clk) begin
    if (w_accept && bus.req_wen && !w_err) begin
      for (int l = 0; l < 4; l++) begin
        if (w_be[l]) r_mem[w_idx][8*l +: 8] <= w_wlanes[8*l +: 8];
      end
    end
  end

  // Results wait LATENCY-1 register stages before entering the response FIFO.
  generate
    if (LATENCY == 1) begin : g_no_pipe
      assign w_head_vld = w_accept;
      assign w_head_pl  = w_in_pl;
    end else begin : g_pipe
      logic [LATENCY-2:0] r_vld;
      logic [PW-1:0]      r_pl [LATENCY-1];

      // NOTE: state registers use non-blocking assignment so every stage samples pre-edge values.
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          r_vld <= '0;
        end else begin
          r_vld[0] <= w_accept;
          for (int s = 1; s < LATENCY - 1; s++) r_vld[s] <= r_vld[s-1];
        end
      end

      always_ff @(posedge clk) begin
        r_pl[0] <= w_in_pl;
        for (int s = 1; s < LATENCY - 1; s++) r_pl[s] <= r_pl[s-1];
      end

      assign w_head_vld = r_vld[LATENCY-2];
      assign w_head_pl  = r_pl[LATENCY-2];
    end
  endgenerate

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (w_head_vld) r_buf[r_wr_ptr] <= w_head_pl;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_head_vld) r_wr_ptr <= next_ptr(r_wr_ptr);
      if (w_pop)      r_rd_ptr <= next_ptr(r_rd_ptr);
      case ({w_head_vld, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // The outstanding limit bounds pipe plus FIFO occupancy, so the FIFO never overflows.
  always_comb begin
    w_out_next = r_outstanding;
    if (w_accept && !w_pop)      w_out_next = r_outstanding + 1'b1;
    else if (!w_accept && w_pop) w_out_next = r_outstanding - 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_outstanding <= '0;
      r_req_ready   <= 1'b0;
    end else begin
      r_outstanding <= w_out_next;
      r_req_ready   <= w_out_next < FULL_CNT;
    end
  end

  assign w_rsp_pl      = r_buf[r_rd_ptr];
  assign bus.rsp_valid = r_count != '0;
  assign w_pop         = bus.rsp_valid && bus.rsp_ready;
  assign bus.rsp_rdata = bus.rsp_valid ? w_rsp_pl[PW-1:1] : 32'd0;
  assign bus.rsp_err   = bus.rsp_valid & w_rsp_pl[0];
  assign bus.req_ready = r_req_ready;
endmodule
